// File: rtl/aes_sram_arbiter.sv
// Arbiter for the shared AES key/state SRAM port.
// Round-robin between key expansion (A) and cipher datapath (B), with optional lock.
module aes_sram_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 128,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              req_a,
   input  logic              req_b,
   input  logic              write_a,
   input  logic              write_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic [DATA_W-1:0] wdata_b,
   input  logic              lock_a,
   input  logic              lock_b,
   output logic              done_a,
   output logic              done_b,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              owner,
   output logic              sramRead,
   output logic              sramWrite,
   output logic [ADDR_W-1:0] sramAddr,
   output logic [DATA_W-1:0] sramWriteValue,
   input  logic [DATA_W-1:0] sramReadValue
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RDWAIT,
      RESP
   } state_t;

   localparam logic [2:0] LAT = 3'(READ_LAT);

   state_t            state_q;
   state_t            state_d;
   logic              owner_q;
   logic              last_q;
   logic              lock_q;
   logic              lock_own_q;
   logic              cmd_write_q;
   logic [ADDR_W-1:0] cmd_addr_q;
   logic [DATA_W-1:0] cmd_wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [2:0]        cnt_q;

   logic elig_a;
   logic elig_b;
   logic grant;
   logic pick;
   logic lock_req;
   logic lock_lk;
   logic release_lock;
   logic rd_hit;

   // last_q = 1 means B was served last, so A has priority.
   always_comb begin
      elig_a       = req_a & ~(lock_q & lock_own_q);
      elig_b       = req_b & ~(lock_q & ~lock_own_q);
      grant        = elig_a | elig_b;
      pick         = (elig_a & elig_b) ? ~last_q : elig_b;
      lock_req     = lock_own_q ? req_b : req_a;
      lock_lk      = lock_own_q ? lock_b : lock_a;
      release_lock = lock_q & ~lock_req & ~lock_lk;
      rd_hit       = (cnt_q == 3'd1);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            state_d = cmd_write_q ? RESP : RDWAIT;
         end
         RDWAIT: begin
            if (rd_hit) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         lock_q      <= 1'b0;
         lock_own_q  <= 1'b0;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         rdata_q     <= '0;
         cnt_q       <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (grant) begin
                  owner_q     <= pick;
                  cmd_write_q <= pick ? write_b : write_a;
                  cmd_addr_q  <= pick ? addr_b : addr_a;
                  cmd_wdata_q <= pick ? wdata_b : wdata_a;
               end else if (release_lock) begin
                  lock_q <= 1'b0;
               end
            end
            ACCESS: begin
               if (!cmd_write_q) begin
                  cnt_q <= LAT;
               end
            end
            RDWAIT: begin
               cnt_q <= cnt_q - 3'd1;
               if (rd_hit) begin
                  rdata_q <= sramReadValue;
               end
            end
            RESP: begin
               last_q     <= owner_q;
               lock_own_q <= owner_q;
               lock_q     <= owner_q ? lock_b : lock_a;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy           = (state_q != IDLE);
   assign owner          = owner_q;
   assign done_a         = (state_q == RESP) & ~owner_q;
   assign done_b         = (state_q == RESP) & owner_q;
   assign rdata          = rdata_q;
   assign sramRead       = (state_q == ACCESS) & ~cmd_write_q;
   assign sramWrite      = (state_q == ACCESS) & cmd_write_q;
   assign sramAddr       = (state_q == ACCESS || state_q == RDWAIT)
                           ? cmd_addr_q : '0;
   assign sramWriteValue = sramWrite ? cmd_wdata_q : '0;

endmodule

// File: tb/tb_aes_sram_arbiter.sv
// Directed bench for aes_sram_arbiter.
// Two instances (READ_LAT 1 and 3) share stimulus, each with its own SRAM model.
module tb_aes_sram_arbiter;

   localparam logic [127:0] AA   = {16{8'hAA}};
   localparam logic [127:0] W1   = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] W2   = 128'h11112222333344445555666677778888;
   localparam logic [127:0] W3   = 128'hCAFEF00DCAFEF00DCAFEF00DCAFEF00D;
   localparam logic [127:0] WA   = 128'hA0A0A0A0A0A0A0A0A0A0A0A0A0A0A0A0;
   localparam logic [127:0] WB   = 128'hB0B0B0B0B0B0B0B0B0B0B0B0B0B0B0B0;
   localparam logic [127:0] JUNK = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         req_a, req_b, write_a, write_b, lock_a, lock_b;
   logic [15:0]  addr_a, addr_b;
   logic [127:0] wdata_a, wdata_b;

   logic         done_a1, done_b1, busy1, owner1, sr1, sw1;
   logic [15:0]  sa1;
   logic [127:0] rdata1, swv1, srv1;
   logic         done_a3, done_b3, busy3, owner3, sr3, sw3;
   logic [15:0]  sa3;
   logic [127:0] rdata3, swv3, srv3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   aes_sram_arbiter #(.ADDR_W(16), .DATA_W(128), .READ_LAT(1)) u_dut1 (
      .clk(clk), .n_rst(n_rst),
      .req_a(req_a), .req_b(req_b),
      .write_a(write_a), .write_b(write_b),
      .addr_a(addr_a), .addr_b(addr_b),
      .wdata_a(wdata_a), .wdata_b(wdata_b),
      .lock_a(lock_a), .lock_b(lock_b),
      .done_a(done_a1), .done_b(done_b1),
      .rdata(rdata1), .busy(busy1), .owner(owner1),
      .sramRead(sr1), .sramWrite(sw1),
      .sramAddr(sa1), .sramWriteValue(swv1),
      .sramReadValue(srv1)
   );

   aes_sram_arbiter #(.ADDR_W(16), .DATA_W(128), .READ_LAT(3)) u_dut3 (
      .clk(clk), .n_rst(n_rst),
      .req_a(req_a), .req_b(req_b),
      .write_a(write_a), .write_b(write_b),
      .addr_a(addr_a), .addr_b(addr_b),
      .wdata_a(wdata_a), .wdata_b(wdata_b),
      .lock_a(lock_a), .lock_b(lock_b),
      .done_a(done_a3), .done_b(done_b3),
      .rdata(rdata3), .busy(busy3), .owner(owner3),
      .sramRead(sr3), .sramWrite(sw3),
      .sramAddr(sa3), .sramWriteValue(swv3),
      .sramReadValue(srv3)
   );

   // SRAM model: data is only valid exactly READ_LAT cycles after the strobe.
   logic [127:0] mem [0:255];
   logic         p1_v;
   logic [7:0]   p1_a;
   logic [2:0]   p3_v;
   logic [7:0]   p3_a [0:2];

   always @(posedge clk) begin
      if (sw1) mem[sa1[7:0]] <= swv1;
      if (sw3) mem[sa3[7:0]] <= swv3;
      if (!n_rst) begin
         mem[0] <= AA;
         p1_v   <= 1'b0;
         p3_v   <= 3'b000;
      end else begin
         p1_v <= sr1;
         p3_v <= {p3_v[1:0], sr3};
      end
      p1_a    <= sa1[7:0];
      p3_a[0] <= sa3[7:0];
      p3_a[1] <= p3_a[0];
      p3_a[2] <= p3_a[1];
   end

   assign srv1 = p1_v ? mem[p1_a] : JUNK;
   assign srv3 = p3_v[2] ? mem[p3_a[2]] : JUNK;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      req_a   = 1'b0; req_b   = 1'b0;
      write_a = 1'b0; write_b = 1'b0;
      lock_a  = 1'b0; lock_b  = 1'b0;
      addr_a  = '0;   addr_b  = '0;
      wdata_a = '0;   wdata_b = '0;
      n_rst   = 1'b0;
      step();
      step();
      n_rst   = 1'b1;
   endtask

   task automatic check_zero3(input string tag);
      check({tag, "_busy"},  128'(busy3),   128'(0));
      check({tag, "_owner"}, 128'(owner3),  128'(0));
      check({tag, "_donea"}, 128'(done_a3), 128'(0));
      check({tag, "_doneb"}, 128'(done_b3), 128'(0));
      check({tag, "_srd"},   128'(sr3),     128'(0));
      check({tag, "_swr"},   128'(sw3),     128'(0));
      check({tag, "_addr"},  128'(sa3),     128'(0));
      check({tag, "_wval"},  swv3,          128'(0));
      check({tag, "_rdata"}, rdata3,        128'(0));
   endtask

   initial begin
      reset_dut();
      check_zero3("rst");
      check("rst_busy1",  128'(busy1),  128'(0));
      check("rst_rdata1", rdata1,       128'(0));

      // single write by A
      req_a = 1'b1; write_a = 1'b1; addr_a = 16'h0010; wdata_a = W1;
      step();
      check("wr_sw",   128'(sw1),  128'(1));
      check("wr_sr",   128'(sr1),  128'(0));
      check("wr_addr", 128'(sa1),  128'h10);
      check("wr_data", swv1,       W1);
      check("wr_done_early", 128'(done_a1), 128'(0));
      step();
      check("wr_done_a", 128'(done_a1), 128'(1));
      check("wr_done_b", 128'(done_b1), 128'(0));
      check("wr_sw_off", 128'(sw1),     128'(0));
      req_a = 1'b0;
      step();
      check("wr_idle_busy", 128'(busy1), 128'(0));
      check("wr_idle_addr", 128'(sa1),   128'(0));

      // read by B, READ_LAT = 1
      reset_dut();
      req_b = 1'b1; write_b = 1'b0; addr_b = 16'h0000;
      step();
      check("rd1_sr",    128'(sr1),    128'(1));
      check("rd1_owner", 128'(owner1), 128'(1));
      step();
      check("rd1_done_early", 128'(done_b1), 128'(0));
      step();
      check("rd1_done",  128'(done_b1), 128'(1));
      check("rd1_rdata", rdata1,        AA);
      req_b = 1'b0;
      step();
      check("rd1_done_off", 128'(done_b1), 128'(0));
      check("rd1_hold",     rdata1,        AA);

      // read by B, READ_LAT = 3
      reset_dut();
      req_b = 1'b1; write_b = 1'b0; addr_b = 16'h0000;
      step();
      check("rd3_sr", 128'(sr3), 128'(1));
      step();
      step();
      step();
      check("rd3_done_early", 128'(done_b3), 128'(0));
      step();
      check("rd3_done",  128'(done_b3), 128'(1));
      check("rd3_rdata", rdata3,        AA);
      req_b = 1'b0;
      step();

      // fairness: both writers held high
      reset_dut();
      req_a = 1'b1; write_a = 1'b1; addr_a = 16'h0020; wdata_a = WA;
      req_b = 1'b1; write_b = 1'b1; addr_b = 16'h0030; wdata_b = WB;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("rr%0d_owner", k), 128'(owner1), 128'(k % 2));
         check($sformatf("rr%0d_addr", k), 128'(sa1),
               (k % 2 == 0) ? 128'h20 : 128'h30);
         step();
         check($sformatf("rr%0d_done_a", k), 128'(done_a1),
               128'(k % 2 == 0));
         check($sformatf("rr%0d_done_b", k), 128'(done_b1),
               128'(k % 2 == 1));
         step();
         if (k == 3) begin
            req_a = 1'b0;
            req_b = 1'b0;
         end
         check($sformatf("rr%0d_idle", k), 128'(busy1), 128'(0));
      end

      // lock: A read-modify-write on 0x10 while B waits
      reset_dut();
      req_a = 1'b1; write_a = 1'b0; addr_a = 16'h0010; lock_a = 1'b1;
      req_b = 1'b1; write_b = 1'b1; addr_b = 16'h0040; wdata_b = WB;
      step();
      check("lk_rd_owner", 128'(owner1), 128'(0));
      check("lk_rd_sr",    128'(sr1),    128'(1));
      step();
      step();
      check("lk_rd_done",  128'(done_a1), 128'(1));
      check("lk_rd_rdata", rdata1,        W1);
      step();
      write_a = 1'b1; wdata_a = W2; lock_a = 1'b0;
      step();
      check("lk_wr_owner", 128'(owner1), 128'(0));
      check("lk_wr_sw",    128'(sw1),    128'(1));
      check("lk_wr_data",  swv1,         W2);
      step();
      check("lk_wr_done_a", 128'(done_a1), 128'(1));
      check("lk_wr_done_b", 128'(done_b1), 128'(0));
      req_a = 1'b0;
      step();
      step();
      check("lk_b_owner", 128'(owner1), 128'(1));
      check("lk_b_addr",  128'(sa1),    128'h40);
      step();
      check("lk_b_done", 128'(done_b1), 128'(1));
      req_b = 1'b0;
      step();

      // reset in the middle of a READ_LAT = 3 read
      reset_dut();
      req_a = 1'b1; write_a = 1'b1; addr_a = 16'h0050; wdata_a = W3;
      step();
      step();
      check("mr_a_done", 128'(done_a3), 128'(1));
      req_a = 1'b0;
      req_b = 1'b1; write_b = 1'b0; addr_b = 16'h0000;
      step();
      step();
      check("mr_b_sr",    128'(sr3),    128'(1));
      check("mr_b_owner", 128'(owner3), 128'(1));
      step();
      step();
      check("mr_rdwait_busy", 128'(busy3), 128'(1));
      n_rst = 1'b0;
      req_a = 1'b1;
      step();
      check_zero3("mr");
      n_rst = 1'b1;
      step();
      check("mr_post_owner", 128'(owner3),  128'(0));
      check("mr_post_sw",    128'(sw3),     128'(1));
      check("mr_post_addr",  128'(sa3),     128'h50);
      check("mr_no_done_b",  128'(done_b3), 128'(0));
      step();
      check("mr_post_done_a", 128'(done_a3), 128'(1));
      req_a = 1'b0;
      step();
      step();
      check("mr_b_owner2", 128'(owner3), 128'(1));
      step();
      step();
      step();
      check("mr_b_done_early", 128'(done_b3), 128'(0));
      step();
      check("mr_b_done",  128'(done_b3), 128'(1));
      check("mr_b_rdata", rdata3,        AA);
      req_b = 1'b0;
      step();

      // held req after done becomes a second access
      reset_dut();
      req_a = 1'b1; write_a = 1'b1; addr_a = 16'h0060; wdata_a = WA;
      step();
      step();
      check("hold_done1", 128'(done_a1), 128'(1));
      step();
      check("hold_idle", 128'(busy1), 128'(0));
      step();
      check("hold_sw2",   128'(sw1), 128'(1));
      check("hold_addr2", 128'(sa1), 128'h60);
      step();
      check("hold_done2", 128'(done_a1), 128'(1));
      req_a = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
